// File: rtl/arm_pkg.sv
// ----------------------------------------------------------------------------
// arm_pkg -- shared definitions for the instruction fetch front end.
//
// Contents:
//   XLEN, WORD_BYTES, PC_STEP, PC8_OFFSET : word-size constants
//   RESET_PC_DEFAULT                      : default first fetch address
//   fetch_state_t / ST_*                  : fetch FSM state encoding
//   fetch_entry_t                         : prefetch queue entry {instr, pc}
//   word_align()                          : clears the byte-offset bits
// ----------------------------------------------------------------------------
package arm_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned WORD_BYTES = 4;

   localparam logic [XLEN-1:0] PC_STEP          = XLEN'(WORD_BYTES);
   localparam logic [XLEN-1:0] PC8_OFFSET       = XLEN'(2 * WORD_BYTES);
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // FETCH: may issue, WAIT: request outstanding,
   // DROP: request outstanding whose data will be thrown away
   typedef logic [1:0] fetch_state_t;
   localparam fetch_state_t ST_FETCH = 2'd0;
   localparam fetch_state_t ST_WAIT  = 2'd1;
   localparam fetch_state_t ST_DROP  = 2'd2;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return a & ~XLEN'(WORD_BYTES - 1);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue -- DEPTH-entry FIFO of {instr, pc} for the fetch unit.
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   push/wdata : enqueue one entry (caller guarantees not full)
//   pop        : dequeue the head (caller guarantees not empty)
//   flush      : empty the queue; wins over push/pop
//   head       : current head entry (meaningful only when !empty)
//   count      : number of valid entries, 0..DEPTH
//   empty      : count == 0
// ----------------------------------------------------------------------------
module fetch_queue
   import arm_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  fetch_entry_t           wdata,
   output fetch_entry_t           head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   count_q;

   // Storage needs no reset: entries are only observed while counted valid
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_q] <= wdata;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else if (flush) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + AW'(1);
         if (pop)  rd_q <= rd_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   assign head  = mem_q[rd_q];
   assign count = count_q;
   assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit -- instruction fetch with a DEPTH-entry prefetch queue.
//
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   imem_req/imem_addr      : instruction-memory read request, word address
//   imem_ack/imem_rdata     : request accepted, read data valid this cycle
//   redirect/redirect_pc    : taken branch / PC write; target low bits ignored
//   instr_valid/instr_ready : head instruction handshake toward decode
//   instr, instr_pc         : head instruction and its address (0 when empty)
//   instr_pc8               : instr_pc + 8 (R15 read value)
//
// Build option: define FETCH_BYPASS_EN to hand an acked word straight to the
// decoder (same cycle, not enqueued) when the queue is empty and the decoder
// is ready. Without it every word goes through the queue.
// ----------------------------------------------------------------------------
module fetch_unit
   import arm_pkg::*;
#(
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] instr_pc8
);

   localparam int unsigned   CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   fetch_state_t  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   drop_addr_q, drop_addr_d;
   logic          run_q;
   logic          deliver;
   logic          bypass;
   logic          push;
   logic          pop;
   logic          q_empty;
   logic [CW-1:0] q_count;
   fetch_entry_t  q_wdata;
   fetch_entry_t  q_head;

   // Only one request is ever outstanding and it is issued only while the
   // queue has a free slot, so the slot is reserved for its data.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      drop_addr_d = drop_addr_q;
      imem_req    = 1'b0;
      deliver     = 1'b0;

      case (state_q)
         ST_FETCH:         imem_req = run_q && (q_count < DEPTH_C) && !redirect;
         ST_WAIT, ST_DROP: imem_req = 1'b1;
         default:          imem_req = 1'b0;
      endcase

      if (redirect) begin
         pc_d = word_align(redirect_pc);
         case (state_q)
            ST_WAIT: begin
               if (imem_ack) begin
                  state_d = ST_FETCH;
               end else begin
                  // keep presenting the in-flight address until its ack
                  state_d     = ST_DROP;
                  drop_addr_d = pc_q;
               end
            end
            ST_DROP: if (imem_ack) state_d = ST_FETCH;
            default: state_d = ST_FETCH;
         endcase
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (imem_req) begin
                  if (imem_ack) deliver = 1'b1;
                  else          state_d = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_ack) begin
                  deliver = 1'b1;
                  state_d = ST_FETCH;
               end
            end
            ST_DROP: if (imem_ack) state_d = ST_FETCH;
            default: state_d = ST_FETCH;
         endcase
         if (deliver) pc_d = pc_q + PC_STEP;
      end
   end

   // In FETCH/WAIT pc_q is the address being requested
   assign imem_addr = (state_q == ST_DROP) ? drop_addr_q : pc_q;

`ifdef FETCH_BYPASS_EN
   assign bypass = deliver && q_empty && instr_ready;
`else
   assign bypass = 1'b0;
`endif

   assign push    = deliver && !bypass;
   assign pop     = !q_empty && instr_ready && !redirect;
   assign q_wdata = '{instr: imem_rdata, pc: pc_q};

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (redirect),
      .wdata (q_wdata),
      .head  (q_head),
      .count (q_count),
      .empty (q_empty)
   );

   // Outputs read as zero when nothing is available
   always_comb begin
      instr_valid = !q_empty;
      instr       = '0;
      instr_pc    = '0;
      if (bypass) begin
         instr_valid = 1'b1;
         instr       = imem_rdata;
         instr_pc    = pc_q;
      end else if (!q_empty) begin
         instr    = q_head.instr;
         instr_pc = q_head.pc;
      end
   end

   assign instr_pc8 = instr_pc + PC8_OFFSET;

   // run_q holds off the first request until the first edge after reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_FETCH;
         pc_q        <= RESET_PC;
         drop_addr_q <= RESET_PC;
         run_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drop_addr_q <= drop_addr_d;
         run_q       <= 1'b1;
      end
   end

endmodule
